adder_selftest_seq: RTL and testbench



---
 rtl/adder_selftest_pkg.sv | 24 ++
 rtl/selftest_exp_pipe.sv | 37 +++
 rtl/adder_selftest_seq.sv | 144 ++++++++++++++
 tb/tb_adder_selftest_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/adder_selftest_pkg.sv
// Shared types, default sizes and the reference adder for the adder self-test sequencer.
// Optional build macro used by the sequencer: SELFTEST_STOP_ON_FAIL_EN.
package adder_selftest_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_LATENCY = 0;
  localparam int DEF_ERR_W   = 8;

  // Widest operand ref_add handles; callers zero-extend and truncate to WIDTH+1.
  localparam int REF_W = 16;

  function automatic logic [REF_W:0] ref_add(input logic [REF_W-1:0] a,
                                             input logic [REF_W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/selftest_exp_pipe.sv
// Expected-value delay line matching the adder's result latency: entries of {valid, a, b, expected}.
// With LATENCY=0 it collapses to a straight connection.
module selftest_exp_pipe #(
  parameter int DW      = 14,
  parameter int LATENCY = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [DW-1:0] push_data,
  output logic [DW-1:0] pop_data
);

  generate
    if (LATENCY == 0) begin : g_wire
      logic unused_ok;
      assign unused_ok = &{1'b0, clk, rst, clr};
      assign pop_data  = push_data;
    end else begin : g_pipe
      logic [DW-1:0] stage [LATENCY];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
        end else if (clr) begin
          for (int i = 0; i < LATENCY; i++) stage[i] <= '0;
        end else begin
          stage[0] <= push_data;
          for (int i = 1; i < LATENCY; i++) stage[i] <= stage[i-1];
        end
      end

      assign pop_data = stage[LATENCY-1];
    end
  endgenerate

endmodule

// File: rtl/adder_selftest_seq.sv
// Exhaustive operand sweep and result checker for the Kogge-Stone adder tile.
// Build macro SELFTEST_STOP_ON_FAIL_EN: end the sweep at the first mismatch.
//
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | driving vector idx, comparing the entry leaving the expected pipe
//   DRAIN | no new vectors; waiting LATENCY cycles for the last results
//   DONE  | results frozen, done high; start begins a fresh sweep
module adder_selftest_seq
  import adder_selftest_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int LATENCY = DEF_LATENCY,
  parameter int ERR_W   = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] dut_sum,
  input  logic             dut_cout,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b
);

  localparam int IW = 2 * WIDTH;
  localparam int PW = 3 * WIDTH + 2;
  localparam logic [1:0] DRAIN_LOAD = (LATENCY > 0) ? 2'(LATENCY - 1) : 2'd0;

  state_t          state, state_nx;
  logic [IW-1:0]   idx;
  logic [1:0]      drain_cnt;
  logic            sweep_go, idx_adv, drain_load, drain_dec;
  logic            idx_last, mismatch, stop_hit;
  logic [WIDTH:0]  exp_now;
  logic [PW-1:0]   push_data, pop_data;
  logic            pop_valid;
  logic [WIDTH-1:0] pop_a, pop_b;
  logic [WIDTH:0]  pop_exp;

  // The index register is the operand register: op_a is the low half, op_b the high half.
  assign op_a     = idx[WIDTH-1:0];
  assign op_b     = idx[IW-1:WIDTH];
  assign idx_last = (idx == {IW{1'b1}});

  assign exp_now   = (WIDTH+1)'(ref_add(REF_W'(op_a), REF_W'(op_b)));
  assign push_data = {state == RUN, op_a, op_b, exp_now};

  selftest_exp_pipe #(
    .DW      (PW),
    .LATENCY (LATENCY)
  ) u_exp_pipe (
    .clk       (clk),
    .rst       (rst),
    .clr       (sweep_go | stop_hit),
    .push_data (push_data),
    .pop_data  (pop_data)
  );

  assign {pop_valid, pop_a, pop_b, pop_exp} = pop_data;

  assign mismatch = pop_valid && (state == RUN || state == DRAIN) &&
                    ({dut_cout, dut_sum} != pop_exp);

`ifdef SELFTEST_STOP_ON_FAIL_EN
  assign stop_hit = mismatch;
`else
  assign stop_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    sweep_go   = 1'b0;
    idx_adv    = 1'b0;
    drain_load = 1'b0;
    drain_dec  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = RUN;
          sweep_go = 1'b1;
        end
      end
      RUN: begin
        if (stop_hit) begin
          state_nx = DONE;
        end else if (idx_last) begin
          state_nx   = (LATENCY == 0) ? DONE : DRAIN;
          drain_load = 1'b1;
        end else begin
          idx_adv = 1'b1;
        end
      end
      DRAIN: begin
        if (stop_hit || drain_cnt == 2'd0) state_nx = DONE;
        else                               drain_dec = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx       <= '0;
      drain_cnt <= 2'd0;
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
    end else if (sweep_go) begin
      idx       <= '0;
      drain_cnt <= 2'd0;
      err_count <= '0;
      fail_a    <= '0;
      fail_b    <= '0;
    end else begin
      if (idx_adv) idx <= idx + 1'b1;
      if (drain_load)     drain_cnt <= DRAIN_LOAD;
      else if (drain_dec) drain_cnt <= drain_cnt - 1'b1;
      // err_count is zero exactly until the first mismatch, so it doubles as the first-fail flag.
      if (mismatch) begin
        if (err_count != {ERR_W{1'b1}}) err_count <= err_count + 1'b1;
        if (err_count == '0) begin
          fail_a <= pop_a;
          fail_b <= pop_b;
        end
      end
    end
  end

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);
  assign pass = done && (err_count == '0);

endmodule

// File: tb/tb_adder_selftest_seq.sv
// Bench for adder_selftest_seq: a LATENCY=0 instance fed by selectable faulty adder models
// and a LATENCY=1 instance fed by a one-register adder, checked against a per-vector sweep model.
module tb_adder_selftest_seq;

  localparam int M_IDEAL = 0;
  localparam int M_S0    = 1;
  localparam int M_C0    = 2;
  localparam int M_REG   = 3;
  localparam int M_RAND  = 4;

`ifdef SELFTEST_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [3:0] op_a0, op_b0, sum0, fail_a0, fail_b0;
  logic [3:0] op_a1, op_b1, sum1, fail_a1, fail_b1;
  logic       cout0, busy0, done0, pass0;
  logic       cout1, busy1, done1, pass1;
  logic [7:0] err0, err1;

  int         mode = M_IDEAL;
  logic [4:0] xor_tab [256];
  logic [4:0] reg0, reg1, ideal0, res0;
  int         n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  adder_selftest_seq #(.WIDTH(4), .LATENCY(0), .ERR_W(8)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .op_a(op_a0), .op_b(op_b0),
    .dut_sum(sum0), .dut_cout(cout0), .busy(busy0), .done(done0), .pass(pass0),
    .err_count(err0), .fail_a(fail_a0), .fail_b(fail_b0));

  adder_selftest_seq #(.WIDTH(4), .LATENCY(1), .ERR_W(8)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .op_a(op_a1), .op_b(op_b1),
    .dut_sum(sum1), .dut_cout(cout1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .fail_a(fail_a1), .fail_b(fail_b1));

  // Adder tile models
  always @(posedge clk) begin
    reg0 <= {1'b0, op_a0} + {1'b0, op_b0};
    reg1 <= {1'b0, op_a1} + {1'b0, op_b1};
  end

  always_comb begin
    ideal0 = {1'b0, op_a0} + {1'b0, op_b0};
    case (mode)
      M_S0:    res0 = ideal0 & 5'b11110;
      M_C0:    res0 = ideal0 & 5'b01111;
      M_REG:   res0 = reg0;
      M_RAND:  res0 = ideal0 ^ xor_tab[{op_b0, op_a0}];
      default: res0 = ideal0;
    endcase
  end

  assign {cout0, sum0} = res0;
  assign {cout1, sum1} = reg1;

  // Sweep model: walk every pair in index order, observed = what the faulty adder shows
  // when vector i is checked (d = adder delay minus checker latency).
  function automatic void model_sweep(input int m, input int d, output int errs,
                                      output int fa, output int fb, output int fi);
    errs = 0; fa = 0; fb = 0; fi = -1;
    for (int i = 0; i < 256; i++) begin
      int a, b, ref_v, obs, j;
      a = i % 16; b = i / 16; ref_v = a + b;
      case (m)
        M_S0:    obs = ref_v & 30;
        M_C0:    obs = ref_v & 15;
        M_RAND:  obs = ref_v ^ int'(xor_tab[i]);
        M_REG:   begin j = i - d; obs = (j < 0) ? 0 : (j % 16 + j / 16); end
        default: obs = ref_v;
      endcase
      if (obs != ref_v) begin
        if (errs < 255) errs++;
        if (fi < 0) begin fi = i; fa = a; fb = b; end
      end
      if (STOP && fi >= 0) break;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start0 = v;
    else          start1 = v;
  endtask

  function automatic logic [31:0] probe(input int sel, input int f);
    logic [31:0] r;
    case (f)
      0:       r = 32'(sel == 0 ? busy0   : busy1);
      1:       r = 32'(sel == 0 ? done0   : done1);
      2:       r = 32'(sel == 0 ? pass0   : pass1);
      3:       r = 32'(sel == 0 ? err0    : err1);
      4:       r = 32'(sel == 0 ? fail_a0 : fail_a1);
      5:       r = 32'(sel == 0 ? fail_b0 : fail_b1);
      6:       r = 32'(sel == 0 ? op_a0   : op_a1);
      default: r = 32'(sel == 0 ? op_b0   : op_b1);
    endcase
    return r;
  endfunction

  // start high for edge 0; cycle c is the interval after edge c-1, sampled at its negedge.
  task automatic run_sweep(input int sel, input bit spur, output int busy_n, output int done_c);
    busy_n = 0; done_c = -1;
    @(negedge clk); set_start(sel, 1'b1);
    @(posedge clk);
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      set_start(sel, 1'b0);
      if (probe(sel, 1) == 32'd1) begin done_c = c; break; end
      if (probe(sel, 0) == 32'd1) busy_n++;
      if (spur && probe(sel, 0) == 32'd1 && $urandom_range(0, 3) == 0) set_start(sel, 1'b1);
    end
  endtask

  task automatic check_sweep(input string tag, input int sel, input int m, input int d,
                             input int lat, input bit spur);
    int errs, fa, fb, fi, busy_n, done_c, exp_busy, last_i;
    model_sweep(m, d, errs, fa, fb, fi);
    exp_busy = (STOP && fi >= 0) ? fi + 1 + lat : 256 + lat;
    last_i   = (STOP && fi >= 0) ? ((fi + lat > 255) ? 255 : fi + lat) : 255;
    run_sweep(sel, spur, busy_n, done_c);
    chk({tag, "_done_cycle"}, done_c, exp_busy + 1);
    chk({tag, "_busy_cycles"}, busy_n, exp_busy);
    chk({tag, "_pass"}, probe(sel, 2), 32'(errs == 0));
    chk({tag, "_err_count"}, probe(sel, 3), errs);
    chk({tag, "_fail_a"}, probe(sel, 4), fa);
    chk({tag, "_fail_b"}, probe(sel, 5), fb);
    chk({tag, "_op_a_hold"}, probe(sel, 6), last_i % 16);
    chk({tag, "_op_b_hold"}, probe(sel, 7), last_i / 16);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_outputs0", {op_a0, op_b0, busy0, done0, pass0, err0, fail_a0, fail_b0}, 0);
    chk("rst_outputs1", {op_a1, op_b1, busy1, done1, pass1, err1, fail_a1, fail_b1}, 0);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) xor_tab[i] = 5'd0;
    do_reset();

    mode = M_IDEAL; check_sweep("ideal", 0, M_IDEAL, 0, 0, 1'b1);
    mode = M_S0;    check_sweep("sum0_sa0", 0, M_S0, 0, 0, 1'b0);
    mode = M_C0;    check_sweep("cout_sa0", 0, M_C0, 0, 0, 1'b1);

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 256; i++)
        xor_tab[i] = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      mode = M_RAND;
      check_sweep($sformatf("rand%0d", r), 0, M_RAND, 0, 0, 1'b1);
    end

    // Registered adder: wrong latency on instance 0, matched latency on instance 1.
    do_reset();
    mode = M_REG; check_sweep("reg_lat0", 0, M_REG, 1, 0, 1'b0);
    check_sweep("reg_lat1", 1, M_REG, 0, 1, 1'b1);

    // Asynchronous reset in the middle of a failing sweep.
    do_reset();
    mode = M_S0;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk);
    @(negedge clk); start0 = 1'b0;
    repeat (99) @(negedge clk);
    chk("pre_rst_err", err0, STOP ? 1 : 49);
    #2 rst = 1'b1;
    #1;
    chk("async_rst0", {op_a0, op_b0, busy0, done0, pass0, err0, fail_a0, fail_b0}, 0);
    chk("async_rst1", {op_a1, op_b1, busy1, done1, pass1, err1, fail_a1, fail_b1}, 0);
    @(negedge clk); rst = 1'b0;
    mode = M_IDEAL; check_sweep("post_rst", 0, M_IDEAL, 0, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
